// File: rtl/prio_pkg.sv
// prio_pkg: shared state/mode encodings and index-wrap helper for the priority encoder.
package prio_pkg;
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    // Position reached after stepping k places below i, wrapping modulo w.
    function automatic int wrap_dec(input int i, input int k, input int w);
        return (i + w - k) % w;
    endfunction
endpackage

// File: rtl/prio_find_high.sv
// prio_find_high: highest-set-bit search starting at start, descending with wrap.
//   vec   - request vector
//   start - first position examined; search runs start..0 then WIDTH-1..start+1
//   idx   - first set position met (0 when none)
//   found - vec had at least one set bit
module prio_find_high
    import prio_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDXW-1:0]  start,
    output logic [IDXW-1:0]  idx,
    output logic             found
);
    // Walk from the farthest position toward start so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (vec[wrap_dec(int'(start), k, WIDTH)]) begin
                idx   = IDXW'(wrap_dec(int'(start), k, WIDTH));
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/param_prio_encoder.sv
// param_prio_encoder: registered fixed/round-robin priority encoder with valid/ready output.
//   clk, rst   - clock, synchronous active-high reset
//   en         - enable; low flushes the held grant and blocks captures
//   mode       - MODE_FIXED (highest index wins) or MODE_RR (rotating start)
//   req        - request vector
//   out_ready  - consumer accepts the current grant
//   out_valid  - out_idx/grant hold a valid grant
//   out_idx    - binary index of the grant
//   grant      - one-hot grant, zero when out_valid is low
module param_prio_encoder
    import prio_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_idx,
    output logic [WIDTH-1:0] grant
);
    state_t           state, state_nxt;
    logic [IDXW-1:0]  ptr, ptr_nxt, idx_nxt, start, win;
    logic [WIDTH-1:0] grant_nxt;
    logic             found, capture;

    // Fixed priority is the same search anchored at the top index.
    assign start = (mode == MODE_RR) ? ptr : IDXW'(WIDTH - 1);

    prio_find_high #(.WIDTH(WIDTH)) u_find (
        .vec  (req),
        .start(start),
        .idx  (win),
        .found(found)
    );

    assign capture   = en && (state == EMPTY || out_ready);
    assign out_valid = (state == HOLD);

    always_comb begin
        state_nxt = state;
        idx_nxt   = out_idx;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        if (!en) begin
            state_nxt = EMPTY;
            grant_nxt = '0;
        end else if (capture) begin
            state_nxt = found ? HOLD : EMPTY;
            idx_nxt   = found ? win : out_idx;
            grant_nxt = found ? WIDTH'(1) << win : '0;
            ptr_nxt   = !found ? ptr : (win == '0) ? IDXW'(WIDTH - 1) : win - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            out_idx <= '0;
            grant   <= '0;
            ptr     <= IDXW'(WIDTH - 1);
        end else begin
            state   <= state_nxt;
            out_idx <= idx_nxt;
            grant   <= grant_nxt;
            ptr     <= ptr_nxt;
        end
    end
endmodule

// File: tb/tb_param_prio_encoder.sv
// tb_param_prio_encoder: directed and random checks against a behavioural model.
module tb_param_prio_encoder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en, mode, out_ready;
    logic [W-1:0] req;
    logic         out_valid;
    logic [2:0]   out_idx;
    logic [W-1:0] grant;

    int checks = 0;
    int errors = 0;

    // model state
    bit           mv;
    int           mi, mp;
    logic [W-1:0] mg;

    always #5 clk = ~clk;

    param_prio_encoder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .req      (req),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_idx  (out_idx),
        .grant    (grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fixed: highest set index. RR: scan ptr down to 0, then top down to ptr+1.
    function automatic int ref_win(input logic [W-1:0] r, input bit m, input int p);
        if (!m) begin
            for (int i = W - 1; i >= 0; i--) if (r[i]) return i;
            return -1;
        end
        for (int i = p; i >= 0; i--) if (r[i]) return i;
        for (int i = W - 1; i > p; i--) if (r[i]) return i;
        return -1;
    endfunction

    task automatic step();
        int w;
        @(posedge clk);
        if (rst) begin
            mv = 0; mi = 0; mg = '0; mp = W - 1;
        end else if (!en) begin
            mv = 0; mg = '0;
        end else if (!mv || out_ready) begin
            w = ref_win(req, mode, mp);
            if (w >= 0) begin
                mv = 1; mi = w; mg = '0; mg[w] = 1'b1; mp = (w + W - 1) % W;
            end else begin
                mv = 0; mg = '0;
            end
        end
        #1;
        chk("valid", 64'(out_valid), 64'(mv));
        chk("idx", 64'(out_idx), 64'(mi));
        chk("grant", 64'(grant), 64'(mg));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        rst = 1'b1; en = 1'b1; mode = 1'b1; out_ready = 1'b1; req = 8'hFF;
        mv = 0; mi = 0; mg = '0; mp = W - 1;
        // reset held two cycles with requests pending
        repeat (2) begin
            step();
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_grant", 64'(grant), 64'd0);
        end
        rst = 1'b0;
        // round-robin rotation on a full request vector
        foreach (seq[i]) begin
            step();
            chk("rr_seq", 64'(out_idx), 64'(seq[i]));
            chk("rr_valid", 64'(out_valid), 64'd1);
        end
        // fixed priority
        do_reset();
        mode = 1'b0; req = 8'b0010_1100;
        step();
        chk("fix_idx", 64'(out_idx), 64'd5);
        chk("fix_grant", 64'(grant), 64'h20);
        // backpressure
        do_reset();
        req = 8'h01;
        step();
        chk("bp_first", 64'(out_idx), 64'd0);
        out_ready = 1'b0; req = 8'h80;
        repeat (5) begin
            step();
            chk("bp_hold", 64'(out_idx), 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next", 64'(out_idx), 64'd7);
        // flush and empty capture
        en = 1'b0;
        step();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_grant", 64'(grant), 64'd0);
        en = 1'b1; req = '0;
        step();
        chk("empty_valid", 64'(out_valid), 64'd0);
        // reset in the middle of round-robin
        do_reset();
        mode = 1'b1; req = 8'hFF;
        step();
        chk("mid_rr0", 64'(out_idx), 64'd7);
        step();
        chk("mid_rr1", 64'(out_idx), 64'd6);
        rst = 1'b1; out_ready = 1'b0;
        step();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("mid_after", 64'(out_idx), 64'd7);
        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            en        = ($urandom_range(0, 9) != 0);
            mode      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            req       = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) req = W'(1) << $urandom_range(0, W - 1);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
